// File: rtl/com_int8_6to1_serializer_if.sv
// Beat-in / lane-out handshake bundle for the 6:1 int8 serializer.
// The slave modport is the serializer's view; master is the driver/consumer side.
interface com_int8_6to1_serializer_if #(
   parameter int DATA_W = 8,
   parameter int LANES  = 6,
   parameter int SEL_W  = 3
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LANES*DATA_W-1:0]   in_data;
   logic [SEL_W-1:0]          in_num;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [SEL_W-1:0]          out_lane;
   logic                      out_last;

   modport slave (
      input  in_valid,
      output in_ready,
      input  in_data,
      input  in_num,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_lane,
      output out_last
   );

   modport master (
      output in_valid,
      input  in_ready,
      output in_data,
      output in_num,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_lane,
      input  out_last
   );
endinterface

// File: rtl/com_int8_6to1_serializer.sv
// Serializes one 6-lane int8 beat into single int8 transfers through an
// internal 6:1 lane mux fed from a holding register.
module com_int8_6to1_mux #(
   parameter int DATA_W = 8,
   parameter int SEL_W  = 3
) (
   input  logic [6*DATA_W-1:0] din,
   input  logic [SEL_W-1:0]    sel,
   output logic [DATA_W-1:0]   dout
);
   always_comb begin
      dout = '0;
      case (sel)
         SEL_W'(0): dout = din[0*DATA_W +: DATA_W];
         SEL_W'(1): dout = din[1*DATA_W +: DATA_W];
         SEL_W'(2): dout = din[2*DATA_W +: DATA_W];
         SEL_W'(3): dout = din[3*DATA_W +: DATA_W];
         SEL_W'(4): dout = din[4*DATA_W +: DATA_W];
         SEL_W'(5): dout = din[5*DATA_W +: DATA_W];
         default:   dout = '0;
      endcase
   end
endmodule

module com_int8_6to1_serializer #(
   parameter int DATA_W = 8,
   parameter int LANES  = 6,
   parameter int SEL_W  = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   com_int8_6to1_serializer_if.slave       bus,
   output logic                            busy
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   localparam logic [SEL_W-1:0] LANES_SEL = SEL_W'(LANES);
   localparam logic [SEL_W-1:0] ONE_SEL   = SEL_W'(1);

   logic [0:0]              state_q, state_d;
   logic [SEL_W-1:0]        sel_q,   sel_d;
   logic [SEL_W-1:0]        cnt_q,   cnt_d;
   logic [LANES*DATA_W-1:0] hold_q,  hold_d;

   logic                    shifting;
   logic                    last_lane;
   logic                    in_fire;
   logic                    out_fire;
   logic [SEL_W-1:0]        eff_cnt;
   logic [DATA_W-1:0]       mux_out;

   com_int8_6to1_mux #(
      .DATA_W (DATA_W),
      .SEL_W  (SEL_W)
   ) u_mux (
      .din  (hold_q),
      .sel  (sel_q),
      .dout (mux_out)
   );

   // Out-of-range lane counts (0, 7) fall back to a full beat.
   always_comb begin
      eff_cnt = bus.in_num;
      if (bus.in_num == '0 || bus.in_num > LANES_SEL) begin
         eff_cnt = LANES_SEL;
      end
   end

   always_comb begin
      shifting  = (state_q == ST_SHIFT);
      last_lane = shifting && (sel_q == cnt_q - ONE_SEL);
      out_fire  = shifting && bus.out_ready;
      // Accepting during SHIFT only on the last transfer keeps beats bubble-free.
      bus.in_ready = !shifting || (bus.out_ready && last_lane);
      in_fire      = bus.in_valid && bus.in_ready;
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (in_fire) begin
         hold_d  = bus.in_data;
         cnt_d   = eff_cnt;
         sel_d   = '0;
         state_d = ST_SHIFT;
      end else if (out_fire) begin
         if (last_lane) begin
            sel_d   = '0;
            state_d = ST_IDLE;
         end else begin
            sel_d = sel_q + ONE_SEL;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
      end
   end

   always_comb begin
      bus.out_valid = shifting;
      bus.out_data  = shifting ? mux_out : '0;
      bus.out_lane  = sel_q;
      bus.out_last  = last_lane;
      busy          = shifting;
   end
endmodule

// File: tb/tb_com_int8_6to1_serializer.sv
// Directed and scoreboarded random stimulus for com_int8_6to1_serializer.
module tb_com_int8_6to1_serializer;
   logic clk = 1'b0;
   logic rst_n;
   logic busy;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   com_int8_6to1_serializer_if #(.DATA_W(8), .LANES(6), .SEL_W(3)) bus ();

   com_int8_6to1_serializer #(.DATA_W(8), .LANES(6), .SEL_W(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .busy  (busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic [7:0] d, input logic [2:0] lane,
                             input logic last);
      check_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      check_eq({tag, "_data"},  64'(bus.out_data),  64'(d));
      check_eq({tag, "_lane"},  64'(bus.out_lane),  64'(lane));
      check_eq({tag, "_last"},  64'(bus.out_last),  64'(last));
   endtask

   task automatic expect_idle(input string tag);
      check_eq({tag, "_idle_valid"}, 64'(bus.out_valid), 64'd0);
      check_eq({tag, "_idle_ready"}, 64'(bus.in_ready),  64'd1);
      check_eq({tag, "_idle_busy"},  64'(busy),          64'd0);
   endtask

   // Presents one beat from IDLE with out_ready held high; n_exp is the hand-derived lane count.
   task automatic send_and_check(input string tag, input logic [47:0] d, input logic [2:0] num,
                                 input int n_exp);
      bus.in_valid  = 1'b1;
      bus.in_data   = d;
      bus.in_num    = num;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '1;
      bus.in_num   = 3'd2;
      for (int i = 0; i < n_exp; i++) begin
         expect_out(tag, d[8*i +: 8], i[2:0], i == n_exp - 1);
         check_eq({tag, "_in_ready"}, 64'(bus.in_ready), 64'(i == n_exp - 1));
         @(negedge clk);
      end
      expect_idle(tag);
   endtask

   logic [11:0] sb[$];
   logic [11:0] front;
   logic        exp_ir;
   int          idx;
   int          n_eff;
   logic        rdy_pat[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_num    = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check_eq("rst_out_data",  64'(bus.out_data),  64'd0);
      check_eq("rst_out_lane",  64'(bus.out_lane),  64'd0);
      check_eq("rst_out_last",  64'(bus.out_last),  64'd0);
      check_eq("rst_busy",      64'(busy),          64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      expect_idle("post_rst");

      // Full beat, partial beat, and clamped counts.
      send_and_check("full",   48'h060504030201, 3'd6, 6);
      send_and_check("part3",  48'h0000_00CCBBAA, 3'd3, 3);
      send_and_check("num0",   48'hF6F5F4F3F2F1, 3'd0, 6);
      send_and_check("num7",   48'h665544332211, 3'd7, 6);
      send_and_check("num1",   48'h99887766554E, 3'd1, 1);

      // Backpressure: outputs must hold while out_ready is low.
      bus.in_valid = 1'b1;
      bus.in_data  = 48'h363534333231;
      bus.in_num   = 3'd6;
      @(negedge clk);
      bus.in_valid = 1'b0;
      idx = 0;
      for (int c = 0; c < 12 && idx < 6; c++) begin
         bus.out_ready = rdy_pat[c];
         #1;
         expect_out("bp", 8'h31 + 8'(idx), 3'(idx), idx == 5);
         check_eq("bp_in_ready", 64'(bus.in_ready), 64'(rdy_pat[c] && idx == 5));
         if (rdy_pat[c]) idx++;
         @(negedge clk);
      end
      check_eq("bp_transfers", 64'(idx), 64'd6);
      expect_idle("bp");

      // Back-to-back beats: no gap, second beat accepted on lane5 of the first.
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 48'h060504030201;
      bus.in_num    = 3'd6;
      @(negedge clk);
      bus.in_data = 48'h161514131211;
      for (int i = 0; i < 12; i++) begin
         if (i == 6) bus.in_valid = 1'b0;
         expect_out("b2b", (i < 6) ? 8'h01 + 8'(i) : 8'h11 + 8'(i - 6), 3'(i % 6), (i % 6) == 5);
         check_eq("b2b_in_ready", 64'(bus.in_ready), 64'(i == 5 || i == 11));
         @(negedge clk);
      end
      expect_idle("b2b");

      // Reset in the middle of a beat.
      bus.in_valid = 1'b1;
      bus.in_data  = 48'h262524232221;
      bus.in_num   = 3'd6;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_out("mid", 8'h21 + 8'(i), 3'(i), 1'b0);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 64'(bus.out_valid), 64'd0);
      check_eq("mid_rst_data",  64'(bus.out_data),  64'd0);
      check_eq("mid_rst_lane",  64'(bus.out_lane),  64'd0);
      check_eq("mid_rst_busy",  64'(busy),          64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_idle("mid_rel");
      @(negedge clk);
      expect_idle("mid_rel2");
      send_and_check("after_rst", 48'h0F0E0D0C0B0A, 3'd6, 6);

      // Random traffic against a lane-queue scoreboard.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         bus.in_valid  = ($urandom_range(0, 99) < 60);
         bus.in_data   = {16'($urandom), 32'($urandom)};
         bus.in_num    = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 99) < 70);
         #1;
         check_eq("rnd_valid", 64'(bus.out_valid), 64'(sb.size() != 0));
         check_eq("rnd_lane_range", 64'(bus.out_lane < 3'd6), 64'd1);
         if (sb.size() != 0) begin
            front = sb[0];
            check_eq("rnd_data", 64'(bus.out_data), 64'(front[7:0]));
            check_eq("rnd_lane", 64'(bus.out_lane), 64'(front[10:8]));
            check_eq("rnd_last", 64'(bus.out_last), 64'(front[11]));
         end
         exp_ir = (sb.size() == 0) || (bus.out_ready && sb.size() == 1);
         check_eq("rnd_in_ready", 64'(bus.in_ready), 64'(exp_ir));
         if (bus.out_ready && sb.size() != 0) void'(sb.pop_front());
         if (bus.in_valid && exp_ir) begin
            n_eff = (bus.in_num == 3'd0 || bus.in_num == 3'd7) ? 6 : int'(bus.in_num);
            for (int l = 0; l < n_eff; l++) begin
               sb.push_back({l == n_eff - 1, 3'(l), bus.in_data[8*l +: 8]});
            end
         end
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      for (int c = 0; c < 20 && sb.size() != 0; c++) begin
         #1;
         front = sb[0];
         check_eq("drain_data", 64'(bus.out_data), 64'(front[7:0]));
         check_eq("drain_lane", 64'(bus.out_lane), 64'(front[10:8]));
         void'(sb.pop_front());
         @(negedge clk);
      end
      check_eq("drain_empty", 64'(sb.size()), 64'd0);
      #1;
      expect_idle("drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
